rh_dbpack: RTL

RH_DBPACK -- requirements
Module: rh_dbpack

---
 rtl/rh_dbpack.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rh_dbpack.sv
`default_nettype none
// ============================================================================
// Module   : rh_dbpack
// Brief    : Packs pairs of 16-bit buffer words into 36-bit memory words
//            ({2'b0, first, 2'b0, second}) and issues them as DMA write
//            requests. Aborts with setDLT if the buffer stays empty too long.
// Revision : 1.0  initial release
// ============================================================================
module rh_dbpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        go,
  input  logic [15:0] wc,
  input  logic        bufOR,
  input  logic [15:0] bufDATA,
  output logic        bufRD,
  output logic        dmaREQ,
  output logic [35:0] dmaDATA,
  input  logic        dmaACK,
  output logic        busy,
  output logic        done,
  output logic        setDLT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_SETTLE = 2'd2,
    S_REQ    = 2'd3
  } state_t;

  // Counter value whose increment this cycle lands on 1023, the data-late limit.
  localparam logic [9:0] TMO_FIRE = 10'd1022;

  state_t      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        half_q, half_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        settle_q, settle_d;
  logic [35:0] data_q, data_d;
  logic        done_q, done_d;
  logic        dlt_q, dlt_d;

  // State register; active-low synchronous reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= 16'd0;
      half_q      <= 1'b0;
      tmo_q       <= 10'd0;
      settle_q    <= 1'b0;
      data_q      <= 36'd0;
      done_q      <= 1'b0;
      dlt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      half_q      <= half_d;
      tmo_q       <= tmo_d;
      settle_q    <= settle_d;
      data_q      <= data_d;
      done_q      <= done_d;
      dlt_q       <= dlt_d;
    end
  end

  // Next-state and read-strobe logic; clr overrides every other input.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    half_d      = half_q;
    tmo_d       = tmo_q;
    settle_d    = settle_q;
    data_d      = data_q;
    done_d      = 1'b0;
    dlt_d       = 1'b0;
    bufRD       = 1'b0;

    if (clr) begin
      state_d     = S_IDLE;
      remaining_d = 16'd0;
      half_d      = 1'b0;
      tmo_d       = 10'd0;
      settle_d    = 1'b0;
      data_d      = 36'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (wc == 16'd0) begin
              done_d = 1'b1;
            end else begin
              remaining_d = wc;
              half_d      = 1'b0;
              data_d      = 36'd0;
              tmo_d       = 10'd0;
              settle_d    = 1'b0;
              state_d     = S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (bufOR) begin
            // The pop is gated by rst so an in-flight reset never steals a word.
            bufRD = rst;
            if (half_q) begin
              data_d[17:0]  = {2'b00, bufDATA};
            end else begin
              data_d[35:18] = {2'b00, bufDATA};
            end
            if (remaining_q != 16'd0) begin
              remaining_d = remaining_q - 16'd1;
            end
            tmo_d    = 10'd0;
            settle_d = 1'b0;
            state_d  = S_SETTLE;
          end else if (tmo_q == TMO_FIRE) begin
            // Data late: drop the partial word and abandon the transfer.
            dlt_d       = 1'b1;
            data_d      = 36'd0;
            remaining_d = 16'd0;
            half_d      = 1'b0;
            tmo_d       = 10'd0;
            state_d     = S_IDLE;
          end else begin
            tmo_d = tmo_q + 10'd1;
          end
        end

        S_SETTLE: begin
          // Two cycles so the buffer head has advanced before the next sample.
          if (!settle_q) begin
            settle_d = 1'b1;
          end else begin
            settle_d = 1'b0;
            if (!half_q && (remaining_q != 16'd0)) begin
              half_d  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_REQ;
            end
          end
        end

        S_REQ: begin
          if (dmaACK) begin
            if (remaining_q != 16'd0) begin
              data_d  = 36'd0;
              half_d  = 1'b0;
              tmo_d   = 10'd0;
              state_d = S_FETCH;
            end else begin
              done_d  = 1'b1;
              half_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign dmaREQ  = (state_q == S_REQ);
  assign busy    = (state_q != S_IDLE);
  assign dmaDATA = data_q;
  assign done    = done_q;
  assign setDLT  = dlt_q;

endmodule
`default_nettype wire
